// File: rtl/fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
//   Read-side pointer and flag controller for the async DDR TX FIFO, clocked in
//   the read domain. It takes the write pointer (Gray code, already through the
//   2-flop synchroniser), owns the read pointer, sequences RAM reads, and drives
//   the empty, almost-empty and level flags. It also returns its Gray read
//   pointer to the write-domain synchroniser.
//
//   Optional build macro: FWFT_EN. When it is defined, a prefetch FSM gives
//   first-word fall-through. When it is undefined (the default), the block runs
//   in standard mode: a pop issues the RAM read, and the data is valid one cycle
//   later.
//
// Ports
//   i_rd_clk        read-domain clock
//   i_rd_rstn       asynchronous active-low reset
//   i_rd_en         read/pop request
//   i_wr_ptr_sync   synchronised write pointer, Gray code (PTR_R+1 bits)
//   o_rd_ptr_gray   registered read pointer, Gray code
//   o_ram_rd_en     RAM read strobe (RAM has a 1-cycle registered read)
//   o_ram_addr      RAM read address
//   i_ram_rdata     RAM read data, valid 1 cycle after o_ram_rd_en
//   o_rd_data       read data to the consumer
//   o_rd_valid      o_rd_data qualifier
//   o_empty         no readable word
//   o_almost_empty  level <= AEMPTY_THRESH
//   o_rd_count      words available
//   o_underflow     sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl #(
  parameter int PTR_R         = 12,
  parameter int DATA_W        = 32,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rstn,
  input  logic              i_rd_en,
  input  logic [PTR_R:0]    i_wr_ptr_sync,
  output logic [PTR_R:0]    o_rd_ptr_gray,
  output logic              o_ram_rd_en,
  output logic [PTR_R-1:0]  o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic [PTR_R:0]    o_rd_count,
  output logic              o_underflow
);

  localparam int            PW    = PTR_R + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] f_gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] f_bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_gray;
  logic [PW-1:0] r_count;
  logic          r_empty;
  logic          r_aempty;
  logic          r_underflow;

  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_count_next;
  logic          w_pop;
  logic          w_uf_set;

  assign w_rd_bin_next  = r_rd_bin + {{PTR_R{1'b0}}, w_pop};
  assign w_rd_gray_next = f_bin2gray(w_rd_bin_next);

`ifdef FWFT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_load;
  logic                w_held;
  logic [DATA_W-1:0]   r_rd_data;

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_empty) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_HOLD;
      S_HOLD:  if (i_rd_en) w_state_next = r_empty ? S_IDLE : S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A RAM read is issued when idle with data waiting, or when a pop in HOLD can
  // be refilled immediately.
  always_comb begin
    w_pop  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:  w_pop  = ~r_empty;
      S_FETCH: w_load = 1'b1;
      S_HOLD:  w_pop  = i_rd_en & ~r_empty;
      default: ;
    endcase
  end

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn)  r_rd_data <= '0;
    else if (w_load) r_rd_data <= i_ram_rdata;
  end

  // A word in flight or in the output register still counts as available.
  assign w_held       = (w_state_next != S_IDLE);
  assign w_count_next = r_wr_bin - w_rd_bin_next + {{PTR_R{1'b0}}, w_held};
  assign o_rd_valid   = (r_state == S_HOLD);
  assign o_empty      = ~o_rd_valid;
  assign w_uf_set     = i_rd_en & ~o_rd_valid;
  assign o_rd_data    = r_rd_data;
`else
  logic r_rd_valid;

  assign w_pop        = i_rd_en & ~r_empty;
  assign w_uf_set     = i_rd_en & r_empty;
  assign w_count_next = r_wr_bin - w_rd_bin_next;

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) r_rd_valid <= 1'b0;
    else            r_rd_valid <= w_pop;
  end

  // The RAM output register holds the word during the valid cycle. The gate
  // keeps the data bus at 0 outside valid cycles, including after reset.
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_valid ? i_ram_rdata : '0;
  assign o_empty    = r_empty;
`endif

  // ---- pointer / flag stage: all state registered from next-state values ----
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      r_wr_bin    <= '0;
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_wr_bin    <= f_gray2bin(i_wr_ptr_sync);
      r_rd_bin    <= w_rd_bin_next;
      r_rd_gray   <= w_rd_gray_next;
      // Empty is compared in Gray against the synchronised pointer. It can only
      // lag the true state, so it never reports data that is not yet written.
      r_empty     <= (w_rd_gray_next == i_wr_ptr_sync);
      r_count     <= w_count_next;
      r_aempty    <= (w_count_next <= AE_TH);
      r_underflow <= r_underflow | w_uf_set;
    end
  end

  assign o_ram_rd_en    = w_pop;
  assign o_ram_addr     = r_rd_bin[PTR_R-1:0];
  assign o_rd_ptr_gray  = r_rd_gray;
  assign o_rd_count     = r_count;
  assign o_almost_empty = r_aempty;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ptr_ctrl
//   Bench for fifo_rd_ptr_ctrl with PTR_R=4, AEMPTY_THRESH=4. It models the
//   registered RAM, where each word equals 0xD0000000 | address. Expected read
//   data is queued when a pop is issued and compared when o_rd_valid appears.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ptr_ctrl;

  localparam int PTR_R  = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              rd_en;
  logic [PTR_R:0]    wr_ptr;
  logic [PTR_R:0]    rd_gray;
  logic              ram_rd_en;
  logic [PTR_R-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              aempty;
  logic [PTR_R:0]    rd_count;
  logic              underflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  fifo_rd_ptr_ctrl #(.PTR_R(PTR_R), .DATA_W(DATA_W), .AEMPTY_THRESH(4)) dut (
    .i_rd_clk      (clk),
    .i_rd_rstn     (rst_n),
    .i_rd_en       (rd_en),
    .i_wr_ptr_sync (wr_ptr),
    .o_rd_ptr_gray (rd_gray),
    .o_ram_rd_en   (ram_rd_en),
    .o_ram_addr    (ram_addr),
    .i_ram_rdata   (ram_q),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_empty       (empty),
    .o_almost_empty(aempty),
    .o_rd_count    (rd_count),
    .o_underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_q <= 32'hD000_0000 | {28'h0, ram_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_valid(input logic exp_v);
    logic [31:0] e;
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underrun: got valid data %0h, expected none", rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    rd_en  = 1'b0;
    wr_ptr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Called at a negedge: drive a pop, check the combinational strobe, and
  // return at the following negedge.
  task automatic pop_step(input logic [3:0] exp_addr);
    rd_en = 1'b1;
    #1;
    chk("ram_rd_en", 32'(ram_rd_en), 32'd1);
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    sb.push_back(32'hD000_0000 | {28'h0, exp_addr});
    @(posedge clk);
    @(negedge clk);
  endtask

`ifndef FWFT_EN
  typedef struct {
    logic       rd;
    logic [4:0] wr;
    logic       en;
    logic [3:0] addr;
    logic       empty;
    logic [4:0] cnt;
    logic       ae;
    logic [4:0] gray;
    logic       uf;
    logic       vld;
  } vec_t;

  vec_t tbl[7];
`endif

  initial begin
    rst_n  = 1'b0;
    rd_en  = 1'b0;
    wr_ptr = '0;
    ram_q  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk("rst_gray", 32'(rd_gray), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ram_en", 32'(ram_rd_en), 32'd0);
    chk("rst_data", rd_data, 32'd0);

`ifndef FWFT_EN
    // Three pops from a pointer of 3, then a read while empty.
    tbl[0] = '{1'b0, 5'b00010, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'b00010, 1'b0, 4'd0, 1'b0, 5'd3, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'b00010, 1'b1, 4'd0, 1'b0, 5'd2, 1'b1, 5'b00001, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 5'b00010, 1'b1, 4'd1, 1'b0, 5'd1, 1'b1, 5'b00011, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'b00010, 1'b1, 4'd2, 1'b1, 5'd0, 1'b1, 5'b00010, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 5'b00010, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 5'b00010, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'b00010, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 5'b00010, 1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      rd_en  = tbl[i].rd;
      wr_ptr = tbl[i].wr;
      #1;
      chk("t_ram_en", 32'(ram_rd_en), 32'(tbl[i].en));
      chk("t_ram_addr", 32'(ram_addr), 32'(tbl[i].addr));
      if (tbl[i].en) sb.push_back(32'hD000_0000 | {28'h0, tbl[i].addr});
      @(posedge clk);
      @(negedge clk);
      chk("t_empty", 32'(empty), 32'(tbl[i].empty));
      chk("t_count", 32'(rd_count), 32'(tbl[i].cnt));
      chk("t_aempty", 32'(aempty), 32'(tbl[i].ae));
      chk("t_gray", 32'(rd_gray), 32'(tbl[i].gray));
      chk("t_uf", 32'(underflow), 32'(tbl[i].uf));
      chk_valid(tbl[i].vld);
    end
    rd_en = 1'b0;

    // Full depth: preload 16, then drain across the address wrap.
    do_reset();
    wr_ptr = 5'b11000;
    repeat (2) @(negedge clk);
    chk("full_count", 32'(rd_count), 32'd16);
    chk("full_empty", 32'(empty), 32'd0);
    chk("full_aempty", 32'(aempty), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pop_step(4'(i));
      chk("drain_count", 32'(rd_count), 32'(15 - i));
      chk("drain_aempty", 32'(aempty), 32'((15 - i) <= 4));
      chk_valid(1'b1);
    end
    rd_en = 1'b0;
    #1;
    chk("drain_gray", 32'(rd_gray), 32'(5'b11000));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    chk_valid(1'b0);

    // Reset in the middle of a burst at count 7.
    do_reset();
    wr_ptr = 5'b01111;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pop_step(4'(i));
      chk("burst_count", 32'(rd_count), 32'(9 - i));
      chk_valid(1'b1);
    end
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_aempty", 32'(aempty), 32'd1);
    chk("mid_count", 32'(rd_count), 32'd0);
    chk("mid_gray", 32'(rd_gray), 32'd0);
    chk("mid_valid", 32'(rd_valid), 32'd0);
    chk("mid_ram_en", 32'(ram_rd_en), 32'd0);
    chk("mid_data", rd_data, 32'd0);
    chk("mid_uf", 32'(underflow), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_valid_next", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
`else
    // First-word fall-through: one word appears without a read request.
    wr_ptr = 5'b00001;
    sb.push_back(32'hD000_0000);
    begin
      int k;
      k = 0;
      while (rd_valid !== 1'b1 && k < 4) begin
        @(negedge clk);
        k++;
      end
      chk("fwft_latency_ok", 32'(k <= 3), 32'd1);
    end
    chk("fwft_empty", 32'(empty), 32'd0);
    chk_valid(1'b1);
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    chk("fwft_empty_after", 32'(empty), 32'd1);
    chk("fwft_valid_after", 32'(rd_valid), 32'd0);
    chk("fwft_uf", 32'(underflow), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
